// File: rtl/aes_mask_pkg.sv
// Shared definitions for the AES mask blocks: FSM encoding, default rotate
// amounts and a generic right-rotate helper.
package aes_mask_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_e;

    localparam int unsigned ROT_AES128 = 19;
    localparam int unsigned ROT_AES256 = 22;

    // Widest block the rotr helper can handle.
    localparam int unsigned MAX_WIDTH = 1024;

    // Right-rotate the low w bits of k by r; bits at and above w must be zero
    // on entry and are zero on return.
    function automatic logic [MAX_WIDTH-1:0] rotr(input logic [MAX_WIDTH-1:0] k,
                                                  input int unsigned w,
                                                  input int unsigned r);
        logic [MAX_WIDTH-1:0] mask;
        mask = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - w);
        return ((k >> r) | (k << (w - r))) & mask;
    endfunction

endpackage

// File: rtl/aes_mask_iter_if.sv
// Command/result bundle between the host sequencer and the mask block.
interface aes_mask_iter_if #(
    parameter int unsigned WIDTH = 128
) ();
    logic             init;
    logic             next;
    logic             finalize;
    logic             keylen;
    logic [WIDTH-1:0] key;
    logic [WIDTH-1:0] block;
    logic [WIDTH-1:0] result;
    logic             ready;
    logic             done;

    modport master (
        output init, next, finalize, keylen, key, block,
        input  result, ready, done
    );

    modport slave (
        input  init, next, finalize, keylen, key, block,
        output result, ready, done
    );
endinterface

// File: rtl/aes_mask_key_rot.sv
// Combinational key rotator: right-rotate by ROT_A or ROT_B selected by mode.
module aes_mask_key_rot
    import aes_mask_pkg::*;
#(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned ROT_A = ROT_AES128,
    parameter int unsigned ROT_B = ROT_AES256
) (
    input  logic [WIDTH-1:0] key_in,
    input  logic             mode,
    output logic [WIDTH-1:0] key_out
);

    // Widen, rotate within WIDTH bits, then narrow back.
    always_comb begin
        key_out = WIDTH'(rotr(MAX_WIDTH'(key_in), WIDTH, mode ? ROT_B : ROT_A));
    end

endmodule

// File: rtl/aes_mask_iter.sv
// Self-sequencing mask block: one accepted `next` runs ROUNDS rounds of
// state ^= key followed by a key rotation, then pulses done.
module aes_mask_iter
    import aes_mask_pkg::*;
#(
    parameter int unsigned WIDTH  = 128,
    parameter int unsigned ROUNDS = 10,
    parameter int unsigned ROT_A  = ROT_AES128,
    parameter int unsigned ROT_B  = ROT_AES256
) (
    input logic            clk,
    input logic            reset_n,
    aes_mask_iter_if.slave bus
);

    localparam int unsigned CTR_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [CTR_W-1:0] LAST_ROUND = CTR_W'(ROUNDS - 1);

    fsm_e             fsm_reg, fsm_next;
    logic [WIDTH-1:0] state_reg, state_next;
    logic [WIDTH-1:0] key_reg, key_next;
    logic [WIDTH-1:0] key_rot;
    logic             mode_reg, mode_next;
    logic [CTR_W-1:0] round_ctr, round_ctr_next;
    logic             done_reg, done_next;

    aes_mask_key_rot #(
        .WIDTH (WIDTH),
        .ROT_A (ROT_A),
        .ROT_B (ROT_B)
    ) u_key_rot (
        .key_in  (key_reg),
        .mode    (mode_reg),
        .key_out (key_rot)
    );

    // State registers; reset clears everything including any run in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_reg   <= IDLE;
            state_reg <= '0;
            key_reg   <= '0;
            mode_reg  <= 1'b0;
            round_ctr <= '0;
            done_reg  <= 1'b0;
        end else begin
            fsm_reg   <= fsm_next;
            state_reg <= state_next;
            key_reg   <= key_next;
            mode_reg  <= mode_next;
            round_ctr <= round_ctr_next;
            done_reg  <= done_next;
        end
    end

    // Command decode in IDLE (init > next > finalize) and round sequencing in RUN.
    always_comb begin
        fsm_next       = fsm_reg;
        state_next     = state_reg;
        key_next       = key_reg;
        mode_next      = mode_reg;
        round_ctr_next = round_ctr;
        done_next      = 1'b0;
        case (fsm_reg)
            IDLE: begin
                if (bus.init) begin
                    state_next = bus.block;
                    key_next   = bus.key;
                end else if (bus.next) begin
                    mode_next      = bus.keylen;
                    round_ctr_next = '0;
                    fsm_next       = RUN;
                end else if (bus.finalize) begin
                    state_next = state_reg ^ bus.block;
                    key_next   = key_reg ^ bus.key;
                end
            end
            RUN: begin
                state_next     = state_reg ^ key_reg;
                key_next       = key_rot;
                round_ctr_next = round_ctr + 1'b1;
                if (round_ctr == LAST_ROUND) begin
                    fsm_next  = IDLE;
                    done_next = 1'b1;
                end
            end
            default: fsm_next = IDLE;
        endcase
    end

    assign bus.result = state_reg;
    assign bus.ready  = (fsm_reg == IDLE);
    assign bus.done   = done_reg;

endmodule

// File: tb/tb_aes_mask_iter.sv
// Scoreboard bench for aes_mask_iter: three parametrisations, expected results
// queued at stimulus time and checked by monitors on each done pulse.
module tb_aes_mask_iter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    aes_mask_iter_if #(.WIDTH(8))   b8 ();
    aes_mask_iter_if #(.WIDTH(128)) b128 ();
    aes_mask_iter_if #(.WIDTH(128)) b3 ();

    aes_mask_iter #(.WIDTH(8), .ROUNDS(2), .ROT_A(1), .ROT_B(2)) dut8 (
        .clk(clk), .reset_n(reset_n), .bus(b8)
    );
    aes_mask_iter #(.WIDTH(128), .ROUNDS(10), .ROT_A(19), .ROT_B(22)) dut128 (
        .clk(clk), .reset_n(reset_n), .bus(b128)
    );
    aes_mask_iter #(.WIDTH(128), .ROUNDS(3), .ROT_A(19), .ROT_B(22)) dut3 (
        .clk(clk), .reset_n(reset_n), .bus(b3)
    );

    int checks = 0;
    int passes = 0;
    int done8 = 0, done128 = 0, done3 = 0;
    int low8 = 0;
    logic [127:0] q8[$];
    logic [127:0] q128[$];
    logic [127:0] q3[$];
    localparam logic [127:0] ONES = '1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: got event, expected none / timeout", name);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitors: pop and compare on each done pulse, count ready-low cycles.
    always @(negedge clk) begin
        if (reset_n) begin
            if (!b8.ready) low8++;
            if (b8.done) begin
                done8++;
                check("dut8 ready with done", 128'(b8.ready), 128'd1);
                if (q8.size() == 0) fail_now("dut8 unexpected done");
                else check("dut8 result", 128'(b8.result), q8.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && b128.done) begin
            done128++;
            if (q128.size() == 0) fail_now("dut128 unexpected done");
            else check("dut128 result", b128.result, q128.pop_front());
        end
    end

    always @(negedge clk) begin
        if (reset_n && b3.done) begin
            done3++;
            if (q3.size() == 0) fail_now("dut3 unexpected done");
            else check("dut3 result", b3.result, q3.pop_front());
        end
    end

    function automatic logic done_of(input int which);
        case (which)
            0: return b8.done;
            1: return b128.done;
            default: return b3.done;
        endcase
    endfunction

    // Poll for done with a cycle budget, then let the monitor run.
    task automatic wait_done(input int which, input string name);
        int n = 0;
        while (!done_of(which) && n < 100) begin
            cyc();
            n++;
        end
        if (n >= 100) fail_now(name);
        @(negedge clk);
        #1;
        cyc();
    endtask

    task automatic cmd8(input logic i, input logic n, input logic f, input logic kl,
                        input logic [7:0] blk, input logic [7:0] k);
        b8.init = i; b8.next = n; b8.finalize = f; b8.keylen = kl;
        b8.block = blk; b8.key = k;
        cyc();
        b8.init = 1'b0; b8.next = 1'b0; b8.finalize = 1'b0;
    endtask

    task automatic cmd_wide(input logic i, input logic n, input logic kl,
                            input logic [127:0] blk, input logic [127:0] k);
        b128.init = i; b128.next = n; b128.finalize = 1'b0; b128.keylen = kl;
        b128.block = blk; b128.key = k;
        b3.init = i; b3.next = n; b3.finalize = 1'b0; b3.keylen = kl;
        b3.block = blk; b3.key = k;
        cyc();
        b128.init = 1'b0; b128.next = 1'b0;
        b3.init = 1'b0; b3.next = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int l0, d0;
        b8.init = 0; b8.next = 0; b8.finalize = 0; b8.keylen = 0; b8.block = '0; b8.key = '0;
        b128.init = 0; b128.next = 0; b128.finalize = 0; b128.keylen = 0;
        b128.block = '0; b128.key = '0;
        b3.init = 0; b3.next = 0; b3.finalize = 0; b3.keylen = 0; b3.block = '0; b3.key = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset result8", 128'(b8.result), 128'd0);
        check("reset ready8", 128'(b8.ready), 128'd1);
        check("reset done8", 128'(b8.done), 128'd0);
        check("reset result128", b128.result, 128'd0);
        check("reset ready128", 128'(b128.ready), 128'd1);
        reset_n = 1'b1;
        cyc();

        // Known vector, mode A: 0x01 then 0x81
        cmd8(1, 0, 0, 0, 8'h00, 8'h01);
        l0 = low8; d0 = done8;
        q8.push_back(128'h81);
        cmd8(0, 1, 0, 0, 8'h00, 8'h00);
        check("round1 result8", 128'(b8.result), 128'h00);
        cyc();
        check("round1 result8 after edge", 128'(b8.result), 128'h01);
        wait_done(0, "dut8 vector done timeout");
        check("vector ready-low cycles", 128'(low8 - l0), 128'd2);
        check("vector done pulses", 128'(done8 - d0), 128'd1);

        // Finalize: state C3, key F0 -> run gives 33 then 4B
        cmd8(1, 0, 0, 0, 8'h3C, 8'h0F);
        cmd8(0, 0, 1, 0, 8'hFF, 8'hFF);
        check("finalize result", 128'(b8.result), 128'hC3);
        check("finalize ready", 128'(b8.ready), 128'd1);
        q8.push_back(128'h4B);
        cmd8(0, 1, 0, 0, 8'h00, 8'h00);
        wait_done(0, "dut8 finalize run timeout");

        // Priority: init wins over next and finalize
        cmd8(1, 1, 1, 0, 8'h55, 8'h0F);
        check("priority result", 128'(b8.result), 128'h55);
        check("priority ready", 128'(b8.ready), 128'd1);
        q8.push_back(128'hDD);
        cmd8(0, 1, 0, 0, 8'h00, 8'h00);
        wait_done(0, "dut8 priority run timeout");

        // init pulsed during RUN is ignored
        cmd8(1, 0, 0, 0, 8'h00, 8'h01);
        d0 = done8;
        q8.push_back(128'h81);
        cmd8(0, 1, 0, 0, 8'h00, 8'h00);
        cmd8(1, 0, 0, 0, 8'hAA, 8'hAA);
        wait_done(0, "dut8 busy run timeout");
        check("busy done pulses", 128'(done8 - d0), 128'd1);

        // Back-to-back with keylen flipped mid-run: 0x81 (ROT_A) then 0xD1 (ROT_B)
        cmd8(1, 0, 0, 0, 8'h00, 8'h01);
        l0 = low8; d0 = done8;
        q8.push_back(128'h81);
        q8.push_back(128'hD1);
        b8.next = 1'b1; b8.keylen = 1'b0;
        cyc();
        b8.keylen = 1'b1;
        begin
            int n = 0;
            while (!b8.done && n < 50) begin
                cyc();
                n++;
            end
            if (n >= 50) fail_now("b2b first done timeout");
        end
        cyc();
        b8.next = 1'b0; b8.keylen = 1'b0;
        wait_done(0, "b2b second done timeout");
        check("b2b ready-low cycles", 128'(low8 - l0), 128'd4);
        check("b2b done pulses", 128'(done8 - d0), 128'd2);

        // All-ones key: even round count cancels, odd leaves all-ones, both modes
        for (int kl = 0; kl < 2; kl++) begin
            cmd_wide(1, 0, 0, 128'd0, ONES);
            q128.push_back(128'd0);
            q3.push_back(ONES);
            cmd_wide(0, 1, kl[0], 128'd0, 128'd0);
            wait_done(2, "dut3 done timeout");
            wait_done(1, "dut128 done timeout");
        end

        // Asynchronous reset mid-run
        cmd_wide(1, 0, 0, 128'h0123456789ABCDEF_FEDCBA9876543210,
                 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0);
        d0 = done128;
        cmd_wide(0, 1, 0, 128'd0, 128'd0);
        repeat (3) cyc();
        check("ready low before reset", 128'(b128.ready), 128'd0);
        #2 reset_n = 1'b0;
        #1;
        check("async reset result", b128.result, 128'd0);
        check("async reset ready", 128'(b128.ready), 128'd1);
        check("async reset done", 128'(b128.done), 128'd0);
        repeat (2) cyc();
        reset_n = 1'b1;
        repeat (12) cyc();
        check("no done after reset", 128'(done128 - d0), 128'd0);
        check("result after reset", b128.result, 128'd0);

        check("q8 drained", 128'(q8.size()), 128'd0);
        check("q128 drained", 128'(q128.size()), 128'd0);
        check("q3 drained", 128'(q3.size()), 128'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
